// File: rtl/mlp_pkg.sv
// Shared types for the MLP layer pipeline: collector FSM encoding and the default data width.
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SCAN    = 2'd2,
    HOLD    = 2'd3
  } collector_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/layer_collector_argmax.sv
// Sequential arg-max over the packed layer bus: one signed compare per step, ties keep the lower index.
// Loaded with slice 0 when collection completes; done_o flags that the next step is the final compare.
module argmax_scanner
  import mlp_pkg::*;
#(
  parameter int n                       = DEFAULT_DATA_WIDTH,
  parameter int number_of_neurons       = 10,
  parameter int clog2_number_of_neurons = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en_i,
  input  logic                               load_i,
  input  logic                               step_i,
  input  logic [number_of_neurons*n-1:0]     data_i,
  output logic                               done_o,
  output logic [clog2_number_of_neurons-1:0] max_index_o,
  output logic [n-1:0]                       max_value_o
);

  localparam int W = clog2_number_of_neurons;
  localparam logic [W-1:0] SECOND_LAST = W'(number_of_neurons - 2);

  logic [W-1:0]        cnt_q;
  logic [W-1:0]        idx_q;
  logic signed [n-1:0] max_q;
  logic signed [n-1:0] cand;
  logic                done_q;

  assign cand = data_i[cnt_q*n +: n];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      max_q  <= '0;
      done_q <= 1'b0;
    end else if (en_i) begin
      if (load_i) begin
        cnt_q  <= W'(1);
        idx_q  <= '0;
        max_q  <= data_i[n-1:0];
        done_q <= (number_of_neurons == 2);
      end else if (step_i) begin
        // Strictly greater only, so an equal later value never steals the index.
        if (cand > max_q) begin
          max_q <= cand;
          idx_q <= cnt_q;
        end
        cnt_q  <= cnt_q + 1'b1;
        done_q <= (cnt_q == SECOND_LAST);
      end
    end
  end

  assign done_o      = done_q;
  assign max_index_o = idx_q;
  assign max_value_o = max_q;

endmodule

// File: rtl/layer_collector.sv
// Collects a layer's neuron results (any order) into one packed bus, offered with valid/ack; ack stalls in HOLD.
// Optional arg-max scan (adds N-1 cycles) is enabled by LAYER_COLLECTOR_ARGMAX_EN.
module layer_collector
  import mlp_pkg::*;
#(
  parameter int n                       = DEFAULT_DATA_WIDTH,
  parameter int number_of_neurons       = 10,
  parameter int clog2_number_of_neurons = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clk_en,
  input  logic                               start,
  output logic                               neuron_go,
  input  logic [number_of_neurons-1:0]       neuron_ready,
  input  logic [number_of_neurons*n-1:0]     neuron_results,
  output logic [number_of_neurons*n-1:0]     layer_data,
  output logic                               layer_valid,
  input  logic                               layer_ack,
  output logic                               busy,
  output logic                               overrun,
  output logic [clog2_number_of_neurons-1:0] max_index,
  output logic [n-1:0]                       max_value
);

  localparam int N = number_of_neurons;

  collector_state_t state_q, state_d;
  logic [N-1:0]     captured_q, captured_d;
  logic [N*n-1:0]   data_q, data_d;
  logic             overrun_q, overrun_d;
  logic             go_q, go_d;
  logic             scan_load, scan_step, scan_done;

  always_comb begin
    state_d    = state_q;
    captured_d = captured_q;
    data_d     = data_q;
    overrun_d  = overrun_q;
    go_d       = 1'b0;
    scan_load  = 1'b0;
    scan_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = COLLECT;
          go_d       = 1'b1;
          captured_d = '0;
          overrun_d  = 1'b0;
        end
      end
      COLLECT: begin
        for (int i = 0; i < N; i++) begin
          if (neuron_ready[i]) begin
            if (captured_q[i]) begin
              overrun_d = 1'b1;
            end else begin
              data_d[i*n +: n] = neuron_results[i*n +: n];
              captured_d[i]    = 1'b1;
            end
          end
        end
        if (&captured_d) begin
`ifdef LAYER_COLLECTOR_ARGMAX_EN
          state_d   = SCAN;
          scan_load = 1'b1;
`else
          state_d   = HOLD;
`endif
        end
      end
`ifdef LAYER_COLLECTOR_ARGMAX_EN
      SCAN: begin
        scan_step = 1'b1;
        if (scan_done) state_d = HOLD;
      end
`endif
      HOLD: begin
        if (|neuron_ready) overrun_d = 1'b1;
        if (layer_ack) begin
          if (start) begin
            state_d    = COLLECT;
            go_d       = 1'b1;
            captured_d = '0;
            overrun_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // clk_en gates every register, so a held neuron_go pulse stays high until the next enabled edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      captured_q <= '0;
      data_q     <= '0;
      overrun_q  <= 1'b0;
      go_q       <= 1'b0;
    end else if (clk_en) begin
      state_q    <= state_d;
      captured_q <= captured_d;
      data_q     <= data_d;
      overrun_q  <= overrun_d;
      go_q       <= go_d;
    end
  end

  assign neuron_go   = go_q;
  assign layer_data  = data_q;
  assign layer_valid = (state_q == HOLD);
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

`ifdef LAYER_COLLECTOR_ARGMAX_EN
  argmax_scanner #(
    .n                       (n),
    .number_of_neurons       (number_of_neurons),
    .clog2_number_of_neurons (clog2_number_of_neurons)
  ) u_argmax (
    .clk         (clk),
    .rst         (rst),
    .en_i        (clk_en),
    .load_i      (scan_load),
    .step_i      (scan_step),
    .data_i      (data_d),
    .done_o      (scan_done),
    .max_index_o (max_index),
    .max_value_o (max_value)
  );
`else
  assign scan_done = 1'b0;
  assign max_index = '0;
  assign max_value = '0;
`endif

endmodule

// File: tb/tb_layer_collector.sv
// Directed bench for layer_collector with N=4, n=8; expectations follow LAYER_COLLECTOR_ARGMAX_EN.
module tb_layer_collector;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;
`ifdef LAYER_COLLECTOR_ARGMAX_EN
  localparam bit ARG = 1'b1;
`else
  localparam bit ARG = 1'b0;
`endif
  localparam int LAT = ARG ? N - 1 : 0;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           clk_en = 1'b1;
  logic           start = 1'b0;
  logic           layer_ack = 1'b0;
  logic [N-1:0]   neuron_ready = '0;
  logic [N*W-1:0] neuron_results = '0;
  logic           neuron_go, layer_valid, busy, overrun;
  logic [N*W-1:0] layer_data;
  logic [CW-1:0]  max_index;
  logic [W-1:0]   max_value;

  int n_cmp = 0;
  int n_err = 0;

  layer_collector #(
    .n                       (W),
    .number_of_neurons       (N),
    .clog2_number_of_neurons (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .start          (start),
    .neuron_go      (neuron_go),
    .neuron_ready   (neuron_ready),
    .neuron_results (neuron_results),
    .layer_data     (layer_data),
    .layer_valid    (layer_valid),
    .layer_ack      (layer_ack),
    .busy           (busy),
    .overrun        (overrun),
    .max_index      (max_index),
    .max_value      (max_value)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] m, input logic [N*W-1:0] d);
    neuron_ready   = m;
    neuron_results = d;
    tick();
    neuron_ready   = '0;
  endtask

  task automatic begin_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (layer_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat;
    n_cmp++; if ({busy, layer_valid, neuron_go, overrun} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {busy, layer_valid, neuron_go, overrun}); end
    n_cmp++; if (layer_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", layer_data); end
    n_cmp++; if ({max_index, max_value} !== '0) begin n_err++; $display("FAIL reset_max: got %h want 0", {max_index, max_value}); end
    tick(); rst = 1'b1; tick();
    begin_pass();
    pulse(4'b0001, 32'h00000055);
    pulse(4'b0010, 32'h00006600);
    pulse(4'b0001, 32'h000000AA);
    n_cmp++; if ({layer_data, overrun} !== {32'h00006655, 1'b1}) begin n_err++; $display("FAIL reset_partial: got %h/%b want 00006655/1", layer_data, overrun); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({busy, layer_valid, neuron_go, overrun} !== 4'b0000) begin n_err++; $display("FAIL reset_mid_flags: got %b want 0000", {busy, layer_valid, neuron_go, overrun}); end
    n_cmp++; if (layer_data !== '0) begin n_err++; $display("FAIL reset_mid_data: got %h want 0", layer_data); end
    tick(); tick(); rst = 1'b1; tick();
    begin_pass();
    n_cmp++; if ({neuron_go, busy} !== 2'b11) begin n_err++; $display("FAIL reset_restart_go: got %b want 11", {neuron_go, busy}); end
    pulse(4'b1110, 32'h44332200);
    n_cmp++; if (layer_valid !== 1'b0) begin n_err++; $display("FAIL reset_captured_clear: got %b want 0", layer_valid); end
    pulse(4'b0001, 32'h00000011);
    wait_valid(lat);
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL reset_latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (layer_data !== 32'h44332211) begin n_err++; $display("FAIL reset_pass_data: got %h want 44332211", layer_data); end
    layer_ack = 1'b1; tick(); layer_ack = 1'b0;
    n_cmp++; if ({layer_valid, busy} !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %b want 00", {layer_valid, busy}); end
  endtask

  task automatic test_in_order();
    int lat;
    begin_pass();
    n_cmp++; if (neuron_go !== 1'b1) begin n_err++; $display("FAIL inorder_go_high: got %b want 1", neuron_go); end
    pulse(4'b0001, 32'h00000005);
    n_cmp++; if (neuron_go !== 1'b0) begin n_err++; $display("FAIL inorder_go_low: got %b want 0", neuron_go); end
    pulse(4'b0010, 32'h0000FD00);
    pulse(4'b0100, 32'h000C0000);
    pulse(4'b1000, 32'h07000000);
    wait_valid(lat);
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL inorder_latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (layer_data !== 32'h070CFD05) begin n_err++; $display("FAIL inorder_data: got %h want 070CFD05", layer_data); end
    n_cmp++; if ({max_index, max_value} !== (ARG ? {2'd2, 8'h0C} : 10'h0)) begin n_err++; $display("FAIL inorder_max: got %0d/%h want %0d/%h", max_index, max_value, ARG ? 2 : 0, ARG ? 8'h0C : 8'h00); end
    layer_ack = 1'b1; tick(); layer_ack = 1'b0;
    n_cmp++; if (layer_valid !== 1'b0) begin n_err++; $display("FAIL inorder_ack: got %b want 0", layer_valid); end
  endtask

  task automatic test_simultaneous();
    int lat;
    begin_pass();
    pulse(4'b1010, 32'h44002200);
    n_cmp++; if (layer_valid !== 1'b0) begin n_err++; $display("FAIL simul_partial: got %b want 0", layer_valid); end
    pulse(4'b0101, 32'h00330011);
    wait_valid(lat);
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL simul_latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (layer_data !== 32'h44332211) begin n_err++; $display("FAIL simul_data: got %h want 44332211", layer_data); end
    n_cmp++; if ({max_index, max_value} !== (ARG ? {2'd3, 8'h44} : 10'h0)) begin n_err++; $display("FAIL simul_max: got %0d/%h", max_index, max_value); end
    layer_ack = 1'b1; tick(); layer_ack = 1'b0;
  endtask

  task automatic test_overrun();
    int lat;
    begin_pass();
    pulse(4'b0010, 32'h00000900);
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_early: got %b want 0", overrun); end
    pulse(4'b0010, 32'h00001400);
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b want 1", overrun); end
    pulse(4'b1101, 32'h03020001);
    wait_valid(lat);
    n_cmp++; if (layer_data !== 32'h03020901) begin n_err++; $display("FAIL overrun_data: got %h want 03020901", layer_data); end
    n_cmp++; if ({max_index, max_value} !== (ARG ? {2'd1, 8'h09} : 10'h0)) begin n_err++; $display("FAIL overrun_max: got %0d/%h", max_index, max_value); end
    layer_ack = 1'b1; tick(); layer_ack = 1'b0;
    n_cmp++; if ({busy, overrun} !== 2'b01) begin n_err++; $display("FAIL overrun_sticky: got %b want 01", {busy, overrun}); end
  endtask

  task automatic test_tie_negative();
    int lat;
    begin_pass();
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL tie_overrun_clear: got %b want 0", overrun); end
    pulse(4'b1001, 32'hFB0000F8);
    pulse(4'b0110, 32'h00FEFE00);
    wait_valid(lat);
    n_cmp++; if (layer_data !== 32'hFBFEFEF8) begin n_err++; $display("FAIL tie_data: got %h want FBFEFEF8", layer_data); end
    n_cmp++; if ({max_index, max_value} !== (ARG ? {2'd1, 8'hFE} : 10'h0)) begin n_err++; $display("FAIL tie_max: got %0d/%h", max_index, max_value); end
  endtask

  task automatic test_handshake();
    int lat;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if ({layer_valid, layer_data} !== {1'b1, 32'hFBFEFEF8}) begin n_err++; $display("FAIL hold_stable_%0d: got %b/%h want 1/FBFEFEF8", k, layer_valid, layer_data); end
    end
    pulse(4'b0001, 32'h0000007F);
    n_cmp++; if ({layer_valid, overrun, layer_data} !== {2'b11, 32'hFBFEFEF8}) begin n_err++; $display("FAIL hold_ready_ignored: got %b%b/%h", layer_valid, overrun, layer_data); end
    layer_ack = 1'b1; start = 1'b1; tick(); layer_ack = 1'b0; start = 1'b0;
    n_cmp++; if ({neuron_go, busy, layer_valid, overrun} !== 4'b1100) begin n_err++; $display("FAIL ack_start: got %b want 1100", {neuron_go, busy, layer_valid, overrun}); end
    pulse(4'b0001, 32'h00000021);
    clk_en = 1'b0;
    neuron_ready = 4'b1110; neuron_results = 32'h99999999;
    tick(); tick(); tick();
    neuron_ready = '0; clk_en = 1'b1;
    n_cmp++; if ({busy, layer_valid, layer_data} !== {2'b10, 32'hFBFEFE21}) begin n_err++; $display("FAIL freeze: got %b%b/%h want 10/FBFEFE21", busy, layer_valid, layer_data); end
    pulse(4'b0110, 32'h00232200);
    n_cmp++; if (layer_valid !== 1'b0) begin n_err++; $display("FAIL freeze_lost: got %b want 0", layer_valid); end
    pulse(4'b1000, 32'h24000000);
    wait_valid(lat);
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL handshake_latency: got %0d want %0d", lat, LAT); end
    n_cmp++; if (layer_data !== 32'h24232221) begin n_err++; $display("FAIL handshake_data: got %h want 24232221", layer_data); end
    n_cmp++; if ({max_index, max_value} !== (ARG ? {2'd3, 8'h24} : 10'h0)) begin n_err++; $display("FAIL handshake_max: got %0d/%h", max_index, max_value); end
    layer_ack = 1'b1; tick(); layer_ack = 1'b0;
    n_cmp++; if ({busy, layer_valid} !== 2'b00) begin n_err++; $display("FAIL handshake_idle: got %b want 00", {busy, layer_valid}); end
  endtask

  initial begin
    tick();
    test_reset();
    test_in_order();
    test_simultaneous();
    test_overrun();
    test_tie_negative();
    test_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/layer_collector.md
# layer_collector

Downstream companion of the neuron stage. Gathers the registered results of a layer's `number_of_neurons` neurons as their one-cycle `ready` pulses arrive in any order. Packs them into one bus in the same layout as a neuron's `datas` input, and presents it to the next layer with a valid/ack handshake. It can also report the arg-max index of the layer, for use as the final classifier stage.

## Interface
Parameters:
- `n`, 8: data width (signed two's complement; same `n` as the neurons)
- `number_of_neurons`, 10: neurons in the layer (N ≥ 2)
- `clog2_number_of_neurons`, 4: index width, equal to ceil(log2 N)

Ports:
- `clk`  in  1  clock; rising edge
- `rst`  in  1  reset; asynchronous, active-low (`rst`=0 resets)
- `clk_en`  in  1  clock enable; when 0, all state, counters and outputs hold
- `start`  in  1  begin a collection pass (level-sampled)
- `neuron_go`  out  1  one-cycle pulse; restarts the layer's neurons
- `neuron_ready`  in  N  per-neuron result-ready pulses
- `neuron_results`  in  N*n  packed neuron results; neuron i at bits [i*n+n-1 : i*n]
- `layer_data`  out  N*n  captured results, same packing
- `layer_valid`  out  1  `layer_data` (and arg-max) stable and valid
- `layer_ack`  in  1  downstream consumed the data
- `busy`  out  1  state ≠ IDLE
- `overrun`  out  1  sticky; a ready pulse arrived for an already-captured neuron
- `max_index`  out  clog2_number_of_neurons  arg-max of `layer_data`
- `max_value`  out  n  value at `max_index`

## Operation
- FSM states: IDLE, COLLECT, SCAN, HOLD.
- **IDLE**
  - `start`=1 → COLLECT.
  - `neuron_go` is registered high for exactly that one cycle.
  - `captured[N-1:0]` clears and `overrun` clears.
- **COLLECT**
  - For each i with `neuron_ready[i]`=1 and `captured[i]`=0: latch slice i of `neuron_results` into slice i of `layer_data`, and set `captured[i]`.
  - Several readies in the same cycle are all captured.
  - `neuron_ready[i]`=1 with `captured[i]`=1: the data is ignored and `overrun` is set.
  - When all `captured` bits would be 1 after this edge → SCAN (`ARGMAX_EN`) or HOLD.
  - `start` is ignored.
- **SCAN** (`ARGMAX_EN` only)
  - Index counter runs 1..N-1, one compare per cycle.
  - Signed compare; the candidate replaces the current maximum only if strictly greater, so ties resolve to the lowest index.
  - Starts from index 0 / slice 0.
  - After the N-1 compare → HOLD.
- **HOLD**
  - `layer_valid`=1; `layer_data`, `max_index` and `max_value` are frozen.
  - `layer_ack`=1 → IDLE.
  - If `start`=1 in the same cycle as `layer_ack`, go directly to COLLECT with a `neuron_go` pulse and captured cleared.
  - `neuron_ready` pulses in HOLD set `overrun`; data is not captured.
- `clk_en`=0 freezes the FSM. Pulses arriving while frozen are lost; this is the neuron clock-enable contract, which runs on the same `clk_en`.
- Reset mid-pass aborts: IDLE, all outputs at their reset values.

## Timing
- Reset values:
  - state IDLE
  - `neuron_go`, `layer_valid`, `busy` and `overrun` = 0
  - `layer_data` = 0, `max_index` = 0, `max_value` = 0
- `neuron_go` is high in the cycle after the edge that sampled `start`.
- Ready-to-valid latency, counted from the edge that samples the last outstanding ready:
  - `layer_valid` rises at that same edge without `ARGMAX_EN`.
  - It rises N-1 edges later with `ARGMAX_EN`.
- `layer_valid` falls at the edge that samples `layer_ack`=1. `layer_ack` outside HOLD is ignored.
- `busy` = registered (state ≠ IDLE).
- `layer_data` slice updates become visible the cycle after the capturing edge.

## Configuration
- Macro: `LAYER_COLLECTOR_ARGMAX_EN`.
- **Defined:** SCAN state, index counter and compare datapath are present; `max_index`/`max_value` are valid whenever `layer_valid`=1.
- **Undefined:** SCAN is removed; COLLECT goes straight to HOLD; `max_index` and `max_value` are tied to 0; the ports remain.

## Structure
- Shared package `mlp_pkg`:
  - state encoding type `collector_state_t` (IDLE, COLLECT, SCAN, HOLD)
  - default data-width constant
- Natural sub-module: `argmax_scanner`. It holds the SCAN counter, the running max and index registers, and a done flag, and is instantiated only under the macro. The FSM and capture registers stay in `layer_collector`.

## Test plan
Configuration for all scenarios: N=4, n=8.
- **Reset:** `rst`=0 mid-COLLECT after two captures → all outputs 0, IDLE. Release, then `start` → a fresh pass with `captured` cleared.
- **In-order collect:** `start`; readies for 0..3 on consecutive cycles with values 5, -3, 12, 7 → `neuron_go` 1 cycle; `layer_data`=(7,12,-3,5) packed; `layer_valid` 0 cycles (no macro) or 3 cycles (macro) after the last ready; with the macro, `max_index`=2 and `max_value`=12.
- **Simultaneous/out-of-order:** readies {3,1} in one cycle, then {0,2} → all four captured; valid as above.
- **Overrun:** neuron 1 pulses ready twice with values 9 then 20 → slice 1 = 9; `overrun`=1 until the next `start`.
- **Tie and negatives (macro):** values -8, -2, -2, -5 → `max_index`=1, `max_value`=-2.
- **Handshake:** hold `layer_ack`=0 for 5 cycles → `layer_valid` and data stable. Then `layer_ack`=1 with `start`=1 → COLLECT with no IDLE cycle and a `neuron_go` pulse. `clk_en`=0 for 3 cycles mid-COLLECT → no state change.
